// File: rtl/sqrt_sched_pkg.sv
// sqrt_sched_pkg: shared types and widths for the square-root scheduler
package sqrt_sched_pkg;
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
  localparam int ID_W = 1;
  function automatic int rem_w(input int w);
    return w / 2 + 1;
  endfunction
endpackage

// File: rtl/sqrt_step.sv
// sqrt_step: one restoring digit-serial square-root iteration (two radicand bits in, one root bit out)
module sqrt_step #(
  parameter int N = 8
) (
  input  logic [N-1:0] q_i,
  input  logic [N+1:0] r_i,
  input  logic [1:0]   d_i,
  output logic [N-1:0] q_o,
  output logic [N+1:0] r_o
);
  logic [N+1:0] rs, t;
  logic ge;
  // the partial remainder is bounded by 2q, so the shifted value always fits N+2 bits
  assign rs = (N+2)'({r_i, d_i});
  assign t = {q_i, 2'b01};
  assign ge = rs >= t;
  assign r_o = ge ? rs - t : rs;
  assign q_o = N'({q_i, ge});
endmodule

// File: rtl/sqrt_scheduler.sv
// sqrt_scheduler: round-robin front end and sequencer for a shared digit-serial square-root engine
module sqrt_scheduler
  import sqrt_sched_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid0,
  input  logic [W-1:0]           i_x0,
  output logic                   o_ready0,
  input  logic                   i_valid1,
  input  logic [W-1:0]           i_x1,
  output logic                   o_ready1,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [ID_W-1:0]        o_id,
  output logic [W/2-1:0]         o_root,
  output logic [rem_w(W)-1:0]    o_rem,
  output logic                   o_busy
);
  localparam int H = W / 2;
  localparam int CW = $clog2(H + 1);
  state_t          state_q;
  logic [W-1:0]    x_q;
  logic [H-1:0]    q_q, q_d;
  logic [H+1:0]    r_q, r_d;
  logic [CW-1:0]   cnt_q;
  logic [ID_W-1:0] id_q;
  logic            ptr_q;
  logic            idle;
  assign idle = state_q == IDLE;
  // ptr_q high means requester 1 is preferred when both are asking
  assign o_ready0 = idle && i_valid0 && (!i_valid1 || !ptr_q);
  assign o_ready1 = idle && i_valid1 && (!i_valid0 || ptr_q);
  assign o_valid = state_q == DONE;
  assign o_busy = !idle;
  assign o_id = id_q;
  assign o_root = q_q;
  assign o_rem = r_q[H:0];
  sqrt_step #(.N(H)) u_step (
    .q_i(q_q),
    .r_i(r_q),
    .d_i(x_q[W-1 -: 2]),
    .q_o(q_d),
    .r_o(r_d)
  );
  // arbitration, operand capture, iteration sequencing and result hold
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      x_q <= '0;
      q_q <= '0;
      r_q <= '0;
      cnt_q <= '0;
      id_q <= '0;
      ptr_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (o_ready0 || o_ready1) begin
          x_q <= o_ready1 ? i_x1 : i_x0;
          id_q <= ID_W'(o_ready1);
          ptr_q <= !o_ready1;
          q_q <= '0;
          r_q <= '0;
          cnt_q <= CW'(H);
          state_q <= ITER;
        end
        ITER: begin
          x_q <= x_q << 2;
          q_q <= q_d;
          r_q <= r_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= DONE;
        end
        DONE: if (i_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/sqrt_scheduler.md
# sqrt_scheduler

Two-port scheduler for the shared digit-serial integer square-root engine. It arbitrates round-robin between two requesters, loads the winning radicand, and steps the engine one result bit per cycle, two radicand bits at a time, MSB first. It then holds the root and remainder on a valid/ready output port until they are taken. It sits between the control FSMs that need square roots and the single root datapath they share.

## Interface
- W, 16, radicand width; even, 4..32.
- i_clk  in  1  system clock, all state on rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_valid0  in  1  requester 0 has an operand.
- i_x0  in  W  requester 0 radicand.
- o_ready0  out  1  requester 0 accepted this cycle when high with i_valid0.
- i_valid1  in  1  requester 1 has an operand.
- i_x1  in  W  requester 1 radicand.
- o_ready1  out  1  requester 1 accept strobe, same rule.
- o_valid  out  1  result available.
- i_ready  in  1  consumer takes result when high with o_valid.
- o_id  out  1  requester that owns the result.
- o_root  out  W/2  floor(sqrt(x)).
- o_rem  out  W/2+1  x - root².
- o_busy  out  1  state is not IDLE.

## Operation
- States: IDLE, ITER, DONE.
- **IDLE:**
  - o_ready0/1 are combinational from state, valids and pointer. At most one is high.
  - Grant rule:
    - Only one valid: that requester wins.
    - Both valid: the requester not served last wins.
    - Pointer resets to "0 preferred".
  - On accept:
    - Latch x and the winner id.
    - Clear root and remainder accumulators.
    - Set the bit counter to W/2.
    - Flip the pointer to prefer the other requester.
    - Go to ITER.
- **ITER:** one step per cycle.
  - r' = (r << 2) | next two MSBs of x. Shift x left by 2.
  - t = (q << 2) | 1.
  - If r' >= t: r = r' - t, q = (q << 1) | 1. Else: r = r', q = q << 1.
  - Decrement the counter. Leave for DONE on the step where the counter reaches 0.
- **DONE:**
  - o_valid = 1. o_root, o_rem and o_id are stable.
  - On i_ready: go to IDLE.
- Arithmetic:
  - r is W/2+2 bits internally, unsigned; no overflow is possible.
  - o_rem uses the low W/2+1 bits.
- Requesters hold valid and operand until their ready. The block samples the operand only on the accept edge.

## Timing
- Reset values: state IDLE, o_valid 0, o_id 0, o_root 0, o_rem 0, o_busy 0, pointer prefers requester 0. o_ready0/1 follow from IDLE, so o_ready0 = i_valid0.
- Latency: accept at edge k. o_valid is high from edge k+W/2 (8 cycles at W=16).
- o_valid stays high, with constant outputs, for as long as i_ready is low.
- Throughput: o_ready is low outside IDLE. After the output handshake at edge m, the earliest next accept is edge m+1, giving W/2+2 cycles per result.
- Both requesters valid continuously: grants strictly alternate 0,1,0,1…
- A requester dropping valid before ready is a protocol violation. The block may already have granted, but it never latches a sample taken outside the accept edge.
- Reset asserted mid-ITER or in DONE: the in-flight result is discarded, o_valid drops at once, and the block returns to reset state. There is no o_valid glitch on deassertion.
- i_ready high while o_valid is low is ignored.

## Structure
- Package sqrt_sched_pkg holds:
  - state enum (IDLE/ITER/DONE);
  - ID width constant (1);
  - a function returning the W/2+1 remainder width.
- Sub-module sqrt_step is the combinational single iteration:
  - inputs: q, r, 2-bit digit;
  - outputs: q', r'.
- The scheduler owns the FSM, arbiter, counter and registers, and instantiates one sqrt_step.

## Test plan
- Reset, requester 0 x=16'd0 → root 0, rem 0, id 0, o_valid exactly 8 cycles after accept.
- x=16'd65535 on requester 1 → root 255, rem 510, id 1.
- x=16'd65025 → root 255, rem 0. x=16'd2 → root 1, rem 1.
- Both requesters valid every cycle, operands 100 and 200 → results alternate id 0 (10,0) and id 1 (14,4), starting with id 0.
- Hold i_ready low 5 cycles in DONE → outputs constant and both readys low. Release → IDLE, accept on the next edge.
- Pulse i_rst_n low during the 4th ITER cycle → o_valid 0, o_busy 0 at once. The next request completes correctly.
